// File: rtl/csi2_packet_controller.sv
// ----------------------------------------------------------------------------
// csi2_packet_controller
//
// Packet-level sequencer between the per-lane D-PHY byte receivers and the
// pixel pipeline of a MIPI CSI-2 receive path. Lane bytes are merged in lane
// order (lane 0 first). Each packet is walked through the header, payload and
// footer phases. The block emits 32-bit pixel words and frame/line events,
// and pulses lane_reset for one cycle at packet end so that the receivers
// re-acquire sync.
//
// Optional feature: define CSI2_ECC_CHECK_EN to check the header ECC byte.
// A header that fails the check raises header_error and is then flushed
// without producing any effect. When the macro is undefined, the ECC byte is
// ignored and header_error is tied to 0.
//
// Ports:
//   clock            byte clock shared by all lanes
//   reset_n          asynchronous active-low reset
//   lane_data        one byte per lane, lane i in [8i+7:8i]
//   lane_enable      per-lane byte valid (thermometer from lane 0)
//   lane_reset       resync request to every D-PHY receiver
//   virtual_channel  VC of the most recent good header
//   data_type        DT of the most recent good header
//   word_count       WC of the most recent good header
//   pixel_data       packed payload word, first byte in [7:0]
//   pixel_valid      one-cycle strobe, pixel_data valid
//   pixel_bytes      number of valid bytes in pixel_data (1-4)
//   pixel_last       with pixel_valid, final word of the packet
//   frame_start / frame_end / line_start / line_end
//                    one-cycle strobes for the short DTs 0x00-0x03
//   frame_number     WC of the last frame start
//   line_count       image long packets seen since frame start
//   header_error     one-cycle strobe on an ECC mismatch
// ----------------------------------------------------------------------------
module csi2_packet_controller #(
    parameter int NUM_LANES = 2
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic [8*NUM_LANES-1:0] lane_data,
    input  logic [NUM_LANES-1:0]   lane_enable,
    output logic [NUM_LANES-1:0]   lane_reset,
    output logic [1:0]             virtual_channel,
    output logic [5:0]             data_type,
    output logic [15:0]            word_count,
    output logic [31:0]            pixel_data,
    output logic                   pixel_valid,
    output logic [2:0]             pixel_bytes,
    output logic                   pixel_last,
    output logic                   frame_start,
    output logic                   frame_end,
    output logic                   line_start,
    output logic                   line_end,
    output logic [15:0]            frame_number,
    output logic [15:0]            line_count,
    output logic                   header_error
);

    typedef enum logic [2:0] {IDLE, HEADER, PAYLOAD, FOOTER, FLUSH} state_t;

    state_t        state_q, state_d;
    logic [16:0]   pos_q, pos_d;          // byte position within the packet
    logic [23:0]   hdr_q, hdr_d;          // DI, WC_lo, WC_hi as they arrive
    logic [31:0]   acc_q, acc_d;          // partial pixel word
    logic [2:0]    accn_q, accn_d;        // bytes held in acc
    logic [1:0]    vc_q, vc_d;
    logic [5:0]    dt_q, dt_d;
    logic [15:0]   wc_q, wc_d;
    logic [31:0]   pdata_q, pdata_d;
    logic          pvld_q, pvld_d;
    logic [2:0]    pbytes_q, pbytes_d;
    logic          plast_q, plast_d;
    logic          fs_q, fs_d, fe_q, fe_d, ls_q, ls_d, le_q, le_d;
    logic [15:0]   fnum_q, fnum_d;
    logic [15:0]   lcnt_q, lcnt_d;
    logic          herr_q, herr_d;

    logic [7:0]    byte_c;
    logic          stop_c;
    logic          last_c;
    logic          ecc_ok_c;

    function automatic logic is_image(input logic [5:0] dt);
        return (dt >= 6'h18) && (dt <= 6'h2F);
    endfunction

`ifdef CSI2_ECC_CHECK_EN
    // CSI-2 header ECC: six parity bits, each an XOR over a fixed subset of
    // the 24 header bits {WC_hi, WC_lo, DI}.
    function automatic logic [5:0] ecc6(input logic [23:0] d);
        logic [5:0] p;
        p[0] = ^(d & 24'hF12CB7);
        p[1] = ^(d & 24'hF2555B);
        p[2] = ^(d & 24'h749A6D);
        p[3] = ^(d & 24'hB8E38E);
        p[4] = ^(d & 24'hDF03F0);
        p[5] = ^(d & 24'hEFFC00);
        return p;
    endfunction
`endif

    always_comb begin
        state_d  = state_q;
        pos_d    = pos_q;
        hdr_d    = hdr_q;
        acc_d    = acc_q;
        accn_d   = accn_q;
        vc_d     = vc_q;
        dt_d     = dt_q;
        wc_d     = wc_q;
        pdata_d  = pdata_q;
        pbytes_d = pbytes_q;
        fnum_d   = fnum_q;
        lcnt_d   = lcnt_q;
        pvld_d   = 1'b0;
        plast_d  = 1'b0;
        fs_d     = 1'b0;
        fe_d     = 1'b0;
        ls_d     = 1'b0;
        le_d     = 1'b0;
        herr_d   = 1'b0;
        byte_c   = 8'h00;
        stop_c   = 1'b0;
        last_c   = 1'b0;
        ecc_ok_c = 1'b1;

        if (state_q == FLUSH) begin
            // One-cycle resync window; every byte offered now is dropped.
            state_d = IDLE;
        end else begin
            // Walk the lanes in order. The FSM may cross several phase
            // boundaries within one cycle. The first disabled lane ends
            // consumption for this cycle.
            for (int i = 0; i < NUM_LANES; i++) begin
                byte_c = lane_data[8*i +: 8];
                if (!lane_enable[i]) stop_c = 1'b1;
                if (!stop_c) begin
                    case (state_d)
                        IDLE: begin
                            hdr_d[7:0] = byte_c;
                            pos_d      = 17'd1;
                            state_d    = HEADER;
                        end
                        HEADER: begin
                            if (pos_d[1:0] == 2'd3) begin
`ifdef CSI2_ECC_CHECK_EN
                                ecc_ok_c = (byte_c == {2'b00, ecc6(hdr_d)});
`endif
                                if (!ecc_ok_c) begin
                                    herr_d  = 1'b1;
                                    state_d = FLUSH;
                                end else begin
                                    vc_d   = hdr_d[7:6];
                                    dt_d   = hdr_d[5:0];
                                    wc_d   = hdr_d[23:8];
                                    pos_d  = 17'd4;
                                    acc_d  = 32'h0;
                                    accn_d = 3'd0;
                                    if (hdr_d[5:0] <= 6'h0F) begin
                                        case (hdr_d[5:0])
                                            6'h00: begin
                                                fs_d   = 1'b1;
                                                fnum_d = hdr_d[23:8];
                                                lcnt_d = 16'h0;
                                            end
                                            6'h01:   fe_d = 1'b1;
                                            6'h02:   ls_d = 1'b1;
                                            6'h03:   le_d = 1'b1;
                                            default: ;
                                        endcase
                                        state_d = FLUSH;
                                    end else begin
                                        if (is_image(hdr_d[5:0])) lcnt_d = lcnt_d + 16'd1;
                                        state_d = (hdr_d[23:8] == 16'h0) ? FOOTER : PAYLOAD;
                                    end
                                end
                            end else begin
                                if (pos_d[1:0] == 2'd1) hdr_d[15:8]  = byte_c;
                                else                    hdr_d[23:16] = byte_c;
                                pos_d = pos_d + 17'd1;
                            end
                        end
                        PAYLOAD: begin
                            // Payload occupies positions 4 .. WC+3.
                            last_c = (pos_d == ({1'b0, wc_d} + 17'd3));
                            if (is_image(dt_d)) begin
                                case (accn_d[1:0])
                                    2'd0:    acc_d[7:0]   = byte_c;
                                    2'd1:    acc_d[15:8]  = byte_c;
                                    2'd2:    acc_d[23:16] = byte_c;
                                    default: acc_d[31:24] = byte_c;
                                endcase
                                accn_d = accn_d + 3'd1;
                                if ((accn_d == 3'd4) || last_c) begin
                                    pdata_d  = acc_d;
                                    pbytes_d = accn_d;
                                    pvld_d   = 1'b1;
                                    plast_d  = last_c;
                                    acc_d    = 32'h0;
                                    accn_d   = 3'd0;
                                end
                            end
                            pos_d = pos_d + 17'd1;
                            if (last_c) state_d = FOOTER;
                        end
                        FOOTER: begin
                            // Checksum bytes at WC+4 and WC+5 are discarded.
                            if (pos_d == ({1'b0, wc_d} + 17'd5)) state_d = FLUSH;
                            pos_d = pos_d + 17'd1;
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            pos_q    <= 17'h0;
            hdr_q    <= 24'h0;
            acc_q    <= 32'h0;
            accn_q   <= 3'd0;
            vc_q     <= 2'd0;
            dt_q     <= 6'd0;
            wc_q     <= 16'h0;
            pdata_q  <= 32'h0;
            pvld_q   <= 1'b0;
            pbytes_q <= 3'd0;
            plast_q  <= 1'b0;
            fs_q     <= 1'b0;
            fe_q     <= 1'b0;
            ls_q     <= 1'b0;
            le_q     <= 1'b0;
            fnum_q   <= 16'h0;
            lcnt_q   <= 16'h0;
            herr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            pos_q    <= pos_d;
            hdr_q    <= hdr_d;
            acc_q    <= acc_d;
            accn_q   <= accn_d;
            vc_q     <= vc_d;
            dt_q     <= dt_d;
            wc_q     <= wc_d;
            pdata_q  <= pdata_d;
            pvld_q   <= pvld_d;
            pbytes_q <= pbytes_d;
            plast_q  <= plast_d;
            fs_q     <= fs_d;
            fe_q     <= fe_d;
            ls_q     <= ls_d;
            le_q     <= le_d;
            fnum_q   <= fnum_d;
            lcnt_q   <= lcnt_d;
            herr_q   <= herr_d;
        end
    end

    assign lane_reset      = {NUM_LANES{state_q == FLUSH}};
    assign virtual_channel = vc_q;
    assign data_type       = dt_q;
    assign word_count      = wc_q;
    assign pixel_data      = pdata_q;
    assign pixel_valid     = pvld_q;
    assign pixel_bytes     = pbytes_q;
    assign pixel_last      = plast_q;
    assign frame_start     = fs_q;
    assign frame_end       = fe_q;
    assign line_start      = ls_q;
    assign line_end        = le_q;
    assign frame_number    = fnum_q;
    assign line_count      = lcnt_q;
    assign header_error    = herr_q;

endmodule
